ccir656_rx: RTL and testbench

- BT.656 / CCIR656 byte-stream receiver. It sits directly downstream of the ccir656 generator and consumes its 8-bit 27 MHz output.
- Detects timing reference sequences (FF 00 00 XY), validates the XY protection bits, and tracks the F/V/H flags.
- Emits active-video bytes with a valid strobe and a component tag, plus line counting and error pulses, for the pixel-processing stages that follow.

---
 rtl/ccir656_rx.sv | 139 +++++++++++++
 tb/tb_ccir656_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccir656_rx.sv
// BT.656 byte-stream receiver: finds FF 00 00 XY timing references, tracks F/V/H,
// and emits tagged active-video bytes with line counting and error pulses.
module ccir656_rx #(
    parameter int ACTIVE_PIXELS = 720,
    parameter int LINE_W        = 10
) (
    input  logic              clk27M,
    input  logic              rst_n,
    input  logic [7:0]        din,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    output logic [1:0]        pix_comp,
    output logic              f,
    output logic              v,
    output logic              h,
    output logic              sav,
    output logic              eav,
    output logic              field_start,
    output logic [LINE_W-1:0] line_cnt,
    output logic              err_prot,
    output logic              err_len
);

    localparam logic [11:0] LP_LINE_BYTES = 12'(2 * ACTIVE_PIXELS);

    logic [7:0]  r_s0, r_s1, r_s2, r_s3;
    logic [3:0]  r_act;          // r_act[i] is the active tag travelling with r_si
    logic        r_active;
    logic        r_locked;
    logic [11:0] r_byte_cnt;
    logic [1:0]  r_comp_phase;

    logic w_trs, w_f, w_v, w_h, w_prot_ok, w_valid;
    logic w_sav, w_eav, w_new_field, w_act_next, w_pix_out;

    always_comb begin
        w_trs       = (r_s3 == 8'hFF) && (r_s2 == 8'h00) && (r_s1 == 8'h00) && r_s0[7];
        w_f         = r_s0[6];
        w_v         = r_s0[5];
        w_h         = r_s0[4];
        w_prot_ok   = (r_s0[3] == (w_v ^ w_h)) && (r_s0[2] == (w_f ^ w_h)) &&
                      (r_s0[1] == (w_f ^ w_v)) && (r_s0[0] == (w_f ^ w_v ^ w_h));
        w_valid     = w_trs && w_prot_ok;
        w_sav       = w_valid && !w_h;
        w_eav       = w_valid && w_h;
        w_new_field = w_valid && r_locked && (w_f != f);
        // TRS bytes never reach the pixel output, valid or not.
        w_pix_out   = r_act[3] && !w_trs;
        // NOTE: assign the default first so every path drives w_act_next and no latch is inferred.
        w_act_next  = r_active;
        if (w_eav) begin
            w_act_next = 1'b0;
        end else if (w_sav && !w_v) begin
            w_act_next = 1'b1;
        end
    end

    // Byte pipeline; the byte entering s0 is tagged with the post-TRS active flag,
    // so the first byte after a SAV XY is already active.
    always_ff @(posedge clk27M or negedge rst_n) begin
        if (!rst_n) begin
            r_s0  <= 8'h00;
            r_s1  <= 8'h00;
            r_s2  <= 8'h00;
            r_s3  <= 8'h00;
            r_act <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            r_s0     <= din;
            r_s1     <= r_s0;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_act[0] <= w_act_next;
            r_act[1] <= r_act[0] && !w_trs;
            r_act[2] <= r_act[1] && !w_trs;
            r_act[3] <= r_act[2] && !w_trs;
        end
    end

    always_ff @(posedge clk27M or negedge rst_n) begin
        if (!rst_n) begin
            pix_data     <= 8'h00;
            pix_valid    <= 1'b0;
            pix_comp     <= 2'd0;
            r_comp_phase <= 2'd0;
            r_byte_cnt   <= 12'd0;
        end else begin
            pix_data  <= r_s3;
            pix_valid <= w_pix_out;
            if (w_pix_out) begin
                pix_comp     <= r_comp_phase;
                r_comp_phase <= r_comp_phase + 2'd1;
                if (r_byte_cnt != 12'hFFF) begin
                    r_byte_cnt <= r_byte_cnt + 12'd1;
                end
            end
            if (w_sav) begin
                r_comp_phase <= 2'd0;
                r_byte_cnt   <= 12'd0;
            end
        end
    end

    always_ff @(posedge clk27M or negedge rst_n) begin
        if (!rst_n) begin
            f           <= 1'b0;
            v           <= 1'b0;
            h           <= 1'b0;
            sav         <= 1'b0;
            eav         <= 1'b0;
            field_start <= 1'b0;
            line_cnt    <= '0;
            err_prot    <= 1'b0;
            err_len     <= 1'b0;
            r_active    <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            sav         <= w_sav;
            eav         <= w_eav;
            field_start <= w_new_field;
            err_prot    <= w_trs && !w_prot_ok;
            // Pixels are counted as they leave s3, so at EAV detection the count is complete.
            err_len     <= w_eav && r_active && (r_byte_cnt != LP_LINE_BYTES);
            r_active    <= w_act_next;
            if (w_valid) begin
                f        <= w_f;
                v        <= w_v;
                h        <= w_h;
                r_locked <= 1'b1;
            end
            if (w_new_field) begin
                line_cnt <= '0;
            end else if (w_eav) begin
                line_cnt <= line_cnt + LINE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ccir656_rx.sv
// Self-checking bench for ccir656_rx: directed stream segments with random pixels,
// checked edge by edge against a stream-parsing reference model.
`timescale 1ns/100ps
module tb_ccir656_rx;

    localparam int ACTIVE_PIXELS = 720;
    localparam int LINE_W        = 10;

    typedef struct packed {
        logic              pv;
        logic [7:0]        pd;
        logic [1:0]        pc;
        logic              sav;
        logic              eav;
        logic              ep;
        logic              el;
        logic              fs;
        logic              f;
        logic              v;
        logic              h;
        logic [LINE_W-1:0] line;
    } out_t;

    logic              clk27M = 1'b0;
    logic              rst_n;
    logic [7:0]        din;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic [1:0]        pix_comp;
    logic              f, v, h, sav, eav, field_start, err_prot, err_len;
    logic [LINE_W-1:0] line_cnt;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   seg_id = 0;
    logic [7:0] stim[$];
    out_t exp_arr[];

    ccir656_rx #(.ACTIVE_PIXELS(ACTIVE_PIXELS), .LINE_W(LINE_W)) dut (
        .clk27M(clk27M), .rst_n(rst_n), .din(din),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_comp(pix_comp),
        .f(f), .v(v), .h(h), .sav(sav), .eav(eav), .field_start(field_start),
        .line_cnt(line_cnt), .err_prot(err_prot), .err_len(err_len)
    );

    always #18 clk27M = ~clk27M;

    function automatic logic [7:0] make_xy(input logic ff, input logic vv, input logic hh);
        return {1'b1, ff, vv, hh, vv ^ hh, ff ^ hh, ff ^ vv, ff ^ vv ^ hh};
    endfunction

    function automatic out_t observe();
        return {pix_valid, pix_data, pix_comp, sav, eav, err_prot, err_len,
                field_start, f, v, h, line_cnt};
    endfunction

    task automatic push_trs(input logic [7:0] xy);
        stim.push_back(8'hFF); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(xy);
    endtask

    task automatic push_px(input int n);
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(1, 254)));
    endtask

    task automatic push_blank(input int n);
        for (int i = 0; i < n; i++) stim.push_back((i % 2 == 0) ? 8'h80 : 8'h10);
    endtask

    // Reference model: scans the byte stream for FF 00 00 XY windows and derives the
    // expected outputs after each sampling edge (XY at byte i acts at edge i+1; a pixel
    // byte j appears at edge j+4).
    task automatic build_model();
        int n;
        bit trs_end[];
        bit supp[];
        logic mf, mv, mh, mlocked, mact, xf, xv, xh, fs;
        logic [LINE_W-1:0] mline;
        logic [7:0] xy;
        int mcnt, mphase;
        n = stim.size();
        exp_arr = new[n];
        trs_end = new[n];
        supp    = new[n];
        for (int i = 0; i < n; i++) begin
            exp_arr[i] = '0;
            trs_end[i] = 1'b0;
            if (i >= 3) begin
                trs_end[i] = (stim[i-3] == 8'hFF) && (stim[i-2] == 8'h00) &&
                             (stim[i-1] == 8'h00) && stim[i][7];
            end
        end
        for (int j = 0; j < n; j++) begin
            supp[j] = 1'b0;
            for (int d = 0; d < 4; d++) if (j + d < n && trs_end[j+d]) supp[j] = 1'b1;
        end
        {mf, mv, mh, mlocked, mact} = '0;
        mline = '0; mcnt = 0; mphase = 0;
        for (int i = 0; i < n; i++) begin
            if (mact && !supp[i]) begin
                if (i + 4 < n) begin
                    exp_arr[i+4].pv = 1'b1;
                    exp_arr[i+4].pd = stim[i];
                    exp_arr[i+4].pc = 2'(mphase);
                end
                mphase = (mphase + 1) % 4;
                if (mcnt < 4095) mcnt++;
            end
            if (trs_end[i]) begin
                xy = stim[i];
                xf = xy[6]; xv = xy[5]; xh = xy[4];
                if (xy != make_xy(xf, xv, xh)) begin
                    if (i + 1 < n) exp_arr[i+1].ep = 1'b1;
                end else begin
                    fs = mlocked && (xf != mf);
                    if (i + 1 < n) exp_arr[i+1].fs = fs;
                    if (fs) mline = '0;
                    if (xh) begin
                        if (i + 1 < n) begin
                            exp_arr[i+1].eav = 1'b1;
                            exp_arr[i+1].el  = mact && (mcnt != 2 * ACTIVE_PIXELS);
                        end
                        if (!fs) mline = mline + 1'b1;
                        mact = 1'b0;
                    end else begin
                        if (i + 1 < n) exp_arr[i+1].sav = 1'b1;
                        mphase = 0;
                        mcnt   = 0;
                        if (!xv) mact = 1'b1;
                    end
                    mf = xf; mv = xv; mh = xh;
                    mlocked = 1'b1;
                end
            end
            if (i + 1 < n) begin
                exp_arr[i+1].f    = mf;
                exp_arr[i+1].v    = mv;
                exp_arr[i+1].h    = mh;
                exp_arr[i+1].line = mline;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        out_t obs;
        obs = observe();
        n_cmp++;
        assert (obs === out_t'('0)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, out_t'('0));
        end
    endtask

    // Called at a falling edge; drives the current stim queue and checks every edge.
    task automatic run_seg();
        out_t obs;
        int n;
        seg_id++;
        build_model();
        n = stim.size();
        din = stim[0];
        for (int e = 0; e < n; e++) begin
            @(negedge clk27M);
            obs = observe();
            if (!exp_arr[e].pv) begin
                obs.pd = 8'h00;
                obs.pc = 2'd0;
            end
            n_cmp++;
            assert (obs === exp_arr[e]) else begin
                n_fail++;
                $error("FAIL seg%0d_edge%0d: observed %h expected %h", seg_id, e, obs, exp_arr[e]);
            end
            if (e + 1 < n) din = stim[e+1];
        end
        din = 8'h10;
        stim.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 8'h00;
        repeat (5) begin
            @(negedge clk27M);
            check_zero("reset_hold");
        end
        rst_n = 1'b1;

        // Idle zeros, full line, short line, bad TRS, F=1 field with V=1, back-to-back
        // TRS, return to F=0, then a line with lone FF/00 data and a restarting SAV.
        repeat (8) stim.push_back(8'h00);
        push_trs(8'h80); push_px(2 * ACTIVE_PIXELS); push_trs(8'h9D);
        push_blank(10);
        push_trs(8'h80); push_px(1000); push_trs(8'h9D);
        push_blank(10);
        push_trs(8'h81);
        push_blank(10);
        push_trs(8'hF1);
        push_blank(6);
        push_trs(8'hEC); push_blank(20); push_trs(8'hF1);
        push_blank(4);
        push_trs(8'hEC); push_trs(8'hF1);
        push_blank(4);
        push_trs(8'h9D);
        push_blank(4);
        push_trs(8'h80);
        stim.push_back(8'h00); stim.push_back(8'hFF); stim.push_back(8'h00);
        stim.push_back(8'h45); stim.push_back(8'hFF); push_px(5);
        push_trs(8'h80); push_px(2 * ACTIVE_PIXELS); push_trs(8'h9D);
        push_blank(8);
        run_seg();

        rst_n = 1'b0;
        #1 check_zero("reset_between");
        repeat (2) @(negedge clk27M);
        rst_n = 1'b1;

        push_blank(4);
        push_trs(8'h80); push_px(200);
        run_seg();

        rst_n = 1'b0;
        #1 check_zero("reset_midline");
        @(negedge clk27M);
        rst_n = 1'b1;

        push_px(300);
        push_trs(8'h80); push_px(2 * ACTIVE_PIXELS); push_trs(8'h9D);
        push_blank(8);
        run_seg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
